// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit pair per clock through a
// single full-adder slice with a registered carry, behind a start/busy/done handshake.

module serial_adder_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_count;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_part_next;

    serial_adder_fa u_fa (
        .i_a (r_sa[0]),
        .i_b (r_sb[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_c)
    );

    assign w_last      = (r_count == CW'(WIDTH - 1));
    // A start in DONE is accepted just like in IDLE, so back-to-back ops lose no cycle.
    assign w_accept    = i_start && (r_state != S_SHIFT);
    assign w_part_next = (r_part >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_SHIFT;
            S_SHIFT: if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = i_start ? S_SHIFT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            S_SHIFT: o_busy = 1'b1;
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_part  <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_sa    <= i_a;
            r_sb    <= i_b;
            r_part  <= '0;
            r_carry <= i_cin;
            r_count <= '0;
        end else if (r_state == S_SHIFT) begin
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_part  <= w_part_next;
            r_carry <= w_c;
            r_count <= r_count + CW'(1);
            // Results only move on the final bit, so sum/cout hold the previous op while busy.
            if (w_last) begin
                r_sum  <= w_part_next;
                r_cout <= w_c;
            end
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1: directed table,
// randomized ops against an integer-addition model, and handshake corner sequences.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst8, rst1;
    logic       st8, st1;
    logic [7:0] a8, b8;
    logic       cin8;
    logic [0:0] a1, b1;
    logic       cin1;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int checks = 0;
    int failures = 0;
    logic [8:0] prev8 = '0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst8), .i_start(st8), .i_a(a8), .i_b(b8), .i_cin(cin8),
        .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_start(st1), .i_a(a1), .i_b(b1), .i_cin(cin1),
        .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_cout(cout1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 op: checks latency, busy length, held result while busy, single done pulse.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input string nm);
        int k;
        int nbusy;
        logic held_ok;
        st8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        tick();
        st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        k = 1; nbusy = 0; held_ok = 1'b1;
        while (!done8 && k < 20) begin
            if (busy8) nbusy++;
            if ({cout8, sum8} !== prev8) held_ok = 1'b0;
            tick();
            k++;
        end
        chk({nm, "_latency"}, 64'(k), 64'd9);
        chk({nm, "_busy_cycles"}, 64'(nbusy), 64'd8);
        chk({nm, "_held_while_busy"}, 64'(held_ok), 64'd1);
        chk({nm, "_sum"}, 64'(sum8), 64'(es));
        chk({nm, "_cout"}, 64'(cout8), 64'(ec));
        tick();
        chk({nm, "_done_single"}, 64'({done8, busy8}), 64'd0);
        prev8 = {ec, es};
    endtask

    task automatic op1(input logic a, input logic b, input logic c, input string nm);
        int k;
        logic [1:0] m;
        m = 2'(a) + 2'(b) + 2'(c);
        st1 = 1'b1; a1 = a; b1 = b; cin1 = c;
        tick();
        st1 = 1'b0;
        chk({nm, "_busy"}, 64'(busy1), 64'd1);
        k = 1;
        while (!done1 && k < 10) begin
            tick();
            k++;
        end
        chk({nm, "_latency"}, 64'(k), 64'd2);
        chk({nm, "_sum_cout"}, 64'({cout1, sum1}), 64'(m));
        tick();
    endtask

    initial begin
        vec_t vecs[4];
        int ndone;
        int dk;
        int last;
        logic [7:0] ra, rb;
        logic rc;
        logic [8:0] m;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};

        rst8 = 1'b1; rst1 = 1'b1; st8 = 1'b0; st1 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        tick(); tick();
        chk("reset8", 64'({busy8, done8, cout8, sum8}), 64'd0);
        chk("reset1", 64'({busy1, done1, cout1, sum1}), 64'd0);
        rst8 = 1'b0; rst1 = 1'b0;
        tick();

        for (int i = 0; i < 4; i++)
            op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            m = 9'(ra) + 9'(rb) + 9'(rc);
            op8(ra, rb, rc, m[7:0], m[8], $sformatf("rnd%0d", i));
        end

        // start pulsed during busy cycle 3 must be ignored
        st8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        tick();
        ndone = 0; dk = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 3) begin st8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
            else st8 = 1'b0;
            if (done8) begin
                ndone++; dk = k;
                chk("ign_sum", 64'({cout8, sum8}), 64'h046);
            end
            tick();
        end
        chk("ign_ndone", 64'(ndone), 64'd1);
        chk("ign_done_cycle", 64'(dk), 64'd9);

        // start held high: back-to-back results every 9 cycles
        st8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1;
        ndone = 0; last = -1;
        for (int c = 1; c <= 28; c++) begin
            tick();
            if (done8) begin
                ndone++;
                if (last >= 0) chk("b2b_period", 64'(c - last), 64'd9);
                last = c;
                chk("b2b_result", 64'({cout8, sum8}), 64'h003);
            end
        end
        chk("b2b_ndone", 64'(ndone), 64'd3);
        st8 = 1'b0;
        for (int c = 0; c < 20 && (busy8 || done8); c++) tick();
        chk("b2b_drained", 64'({busy8, done8}), 64'd0);

        // reset during busy cycle 4 aborts the op
        st8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
        tick();
        st8 = 1'b0;
        tick(); tick(); tick();
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        chk("rst_mid_outputs", 64'({busy8, done8, cout8, sum8}), 64'd0);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            if (done8 || busy8) ndone++;
            tick();
        end
        chk("rst_mid_no_done", 64'(ndone), 64'd0);
        prev8 = '0;
        op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "post_rst");

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op1(v[2], v[1], v[0], $sformatf("w1_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder built around the gate-level full-adder cell: latches two WIDTH-bit operands plus carry-in, then feeds one bit pair per clock through a single full-adder slice with a registered carry. Sits directly downstream of the full-adder primitive and consumes its sum/carry outputs every cycle. Trades WIDTH cycles of latency for one adder cell. Uses a start/busy/done handshake for use by a host FSM or switch/LED test harness.

## Interface
- one clock; reset is synchronous and active-high
- WIDTH, 8, operand and result width in bits; legal range 1..32
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A, captured on an accepted start
- b  input  WIDTH  operand B, captured on an accepted start
- cin  input  1  carry-in, captured on an accepted start
- busy  output  1  high while bits are being added
- done  output  1  single-cycle pulse when sum/cout are updated
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered final carry, held until next completion

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. On start=1: load shift_a<=a, shift_b<=b, carry<=cin, count<=0, clear partial-sum register; go to SHIFT.
- SHIFT: busy=1. Each cycle, the full-adder slice computes s = shift_a[0]^shift_b[0]^carry and c = majority(shift_a[0], shift_b[0], carry). s is shifted into the partial-sum MSB (partial >> 1 | s<<(WIDTH-1)), shift_a/shift_b shift right by 1, carry<=c, count<=count+1. When count reaches WIDTH-1 on that cycle, load sum<=final partial, cout<=c, and go to DONE.
- DONE: done=1, busy=0, for exactly one cycle. start=1 in DONE is accepted as in IDLE, giving a direct transition to SHIFT. Otherwise the FSM goes to IDLE.
- start while busy=1 is ignored: no capture and no effect on the operation in flight.
- Operand inputs are don't-care except on the accepted-start cycle.
- Arithmetic: {cout,sum} = a + b + cin, exact, modulo 2^(WIDTH+1). No overflow flag.
- count width is clog2(WIDTH+1). count does not wrap within an operation.
- sum/cout change only on the SHIFT→DONE transition. They are stable during busy and show the previous result.

## Timing
- Reset (rst=1 at a clock edge): state=IDLE, busy=0, done=0, sum=0, cout=0, and all internal shift/carry/count registers are 0. This takes priority over start and over any operation in flight.
- Reset mid-SHIFT aborts the operation. No done pulse follows, and sum/cout read 0.
- Latency: let start be accepted at edge E0. busy is high for cycles E0+1..E0+WIDTH. done and the new sum/cout are visible in cycle E0+WIDTH+1.
- Throughput: with start held high, one result every WIDTH+1 cycles.
- WIDTH=1: one SHIFT cycle, then DONE. This is equivalent to a registered full adder with 2-cycle latency.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8. Sequence: reset, then start with a=0x5A, b=0x3C, cin=0. Required: busy high for 8 cycles, done pulses at start+9, sum=0x96, cout=0.
- WIDTH=8. Apply a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then apply a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1. These cases check full carry ripple.
- WIDTH=8. Start with a=0x12, b=0x34, cin=0. Pulse start with a=0xFF, b=0xFF at busy cycle 3. Required: one done only, with sum=0x46, cout=0. The second request is ignored.
- WIDTH=8. Hold start=1 continuously with a=0x01, b=0x01, cin=1. Required: done pulses every 9 cycles, and every result is sum=0x03, cout=0. This checks back-to-back acceptance from DONE.
- WIDTH=8. Start with a=0xAA, b=0x55. Assert rst at busy cycle 4. Required: busy=0 next cycle, no done pulse, sum=0x00, cout=0. A following start with a=0x01, b=0x02 completes normally with sum=0x03.
- WIDTH=1. Apply all 8 combinations of a, b, cin. Required: {cout,sum} matches the full-adder truth table, and each done arrives 2 cycles after start.
